// File: rtl/fifo_wr_ptr_pkt.sv
// Write-side pointer and flag controller for the asynchronous Ethernet FIFO.
// Keeps the binary working write pointer, publishes the committed pointer to the
// read domain in Gray code, and brings the read domain's Gray pointer in through
// a synchroniser. It derives full/almost_full from the working pointer.
// In packet mode a frame becomes visible to the reader only when its last word
// is written. A dropped or overflowing frame rolls the working pointer back to
// the last commit point.
module fifo_wr_ptr_pkt #(
  parameter int ADDR_WIDTH       = 4,
  parameter int ALMOST_FULL_DIFF = 4,
  parameter int SYNC_STAGES      = 2,
  parameter int PACKET_MODE      = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  write,
  input  logic                  wr_last,
  input  logic                  wr_drop,
  input  logic [ADDR_WIDTH:0]   rd_ptr,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   w_ptr,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_LEVEL = PW'((2 ** ADDR_WIDTH) - ALMOST_FULL_DIFF);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_DISCARD
  } state_t;

  state_t                         state_q, state_d;
  logic [PW-1:0]                  wr_bin_q, wr_bin_d;
  logic [PW-1:0]                  commit_bin_q, commit_bin_d;
  logic [ADDR_WIDTH-1:0]          wr_addr_q;
  logic [PW-1:0]                  w_ptr_q, w_ptr_d;
  logic                           full_q, full_d;
  logic                           af_q, af_d;
  logic                           ovf_q, ovf_d;
  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;

  logic [PW-1:0] rd_sync;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] wr_bin_inc;
  logic [PW-1:0] wr_gray_d;
  logic [PW-1:0] used_d;
  logic          acc;
  logic          write_full;

  // Shift the raw Gray read pointer through the synchroniser chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rd_ptr};
    end
  end

  assign rd_sync = sync_q[SYNC_STAGES-1];

  // Gray to binary: each binary bit is the XOR of all Gray bits at and above it.
  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_gray2bin
      assign rd_bin[gi] = ^rd_sync[ADDR_WIDTH:gi];
    end
  endgenerate

  // Accept logic, frame FSM, pointer next state and flag lookahead.
  always_comb begin
    state_d      = state_q;
    commit_bin_d = commit_bin_q;
    ovf_d        = 1'b0;

    if (PACKET_MODE != 0) begin
      acc = write & ~full_q & (state_q != ST_DISCARD) & ~wr_drop;
    end else begin
      acc = write & ~full_q;
    end
    write_full = write & full_q;
    wr_bin_inc = wr_bin_q + PW'(acc);
    wr_bin_d   = wr_bin_inc;

    if (PACKET_MODE == 0) begin
      commit_bin_d = wr_bin_inc;
      state_d      = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acc) begin
            if (wr_last) begin
              commit_bin_d = wr_bin_inc;
            end else begin
              state_d = ST_FRAME;
            end
          end else if (write_full && !wr_drop) begin
            if (wr_last) begin
              wr_bin_d = commit_bin_q;
              ovf_d    = 1'b1;
            end else begin
              state_d = ST_DISCARD;
            end
          end
        end
        ST_FRAME: begin
          if (wr_drop) begin
            // Abandon the frame; any write presented alongside the drop is lost.
            wr_bin_d = commit_bin_q;
            state_d  = ST_IDLE;
          end else if (acc && wr_last) begin
            commit_bin_d = wr_bin_inc;
            state_d      = ST_IDLE;
          end else if (write_full) begin
            if (wr_last) begin
              wr_bin_d = commit_bin_q;
              ovf_d    = 1'b1;
              state_d  = ST_IDLE;
            end else begin
              state_d = ST_DISCARD;
            end
          end
        end
        ST_DISCARD: begin
          // Swallow the rest of the frame; only an end-of-frame exit reports overflow.
          if (wr_drop) begin
            wr_bin_d = commit_bin_q;
            state_d  = ST_IDLE;
          end else if (write && wr_last) begin
            wr_bin_d = commit_bin_q;
            ovf_d    = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    w_ptr_d   = commit_bin_d ^ (commit_bin_d >> 1);
    wr_gray_d = wr_bin_d ^ (wr_bin_d >> 1);
    full_d    = (wr_gray_d == {~rd_sync[ADDR_WIDTH:ADDR_WIDTH-1], rd_sync[ADDR_WIDTH-2:0]});
    used_d    = wr_bin_d - rd_bin;
    af_d      = (used_d >= AF_LEVEL);
  end

  // Register pointers, flags and FSM state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wr_bin_q     <= '0;
      commit_bin_q <= '0;
      wr_addr_q    <= '0;
      w_ptr_q      <= '0;
      full_q       <= 1'b0;
      af_q         <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_bin_q     <= wr_bin_d;
      commit_bin_q <= commit_bin_d;
      wr_addr_q    <= wr_bin_d[ADDR_WIDTH-1:0];
      w_ptr_q      <= w_ptr_d;
      full_q       <= full_d;
      af_q         <= af_d;
      ovf_q        <= ovf_d;
    end
  end

  assign mem_we      = acc;
  assign wr_addr     = wr_addr_q;
  assign w_ptr       = w_ptr_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign overflow    = ovf_q;

endmodule
